spectrum_frame_buffer: RTL and testbench
========================================

Name: spectrum_frame_buffer

Overview:
- Sits directly downstream of the FFT block on the frequency-clock domain.
- Consumes the power-spectrum byte stream (flgFreqSampleValid/addrFreq/byteFreqSample) and keeps bins 0..NBINS-1 of each frame in a ping-pong buffer.
- Applies optional exponential averaging and tracks the per-frame peak bin.
- Exposes a tear-free random-access read port for the display/plot logic.

Parameters:
- NBINS, 512, bins captured per frame (power of 2, at most 1024); bins at or above NBINS are ignored.
- ABITS, 9, log2(NBINS); width of addrDisplay and peakBin.

Ports:
- ckFreq  in  1  frequency-domain clock; all logic is on its rising edge.
- aresetn  in  1  asynchronous active-low reset.
- flgFreqSampleValid  in  1  input bin valid.
- addrFreq  in  10  input bin index.
- byteFreqSample  in  8  input bin power, unsigned.
- flgFreeze  in  1  when 1, completed frames are not committed.
- avgShift  in  2  averaging exponent k; 0 means no averaging.
- addrDisplay  in  ABITS  display read address.
- byteDisplay  out  8  display read data; 1-cycle latency.
- flgFrameDone  out  1  one-cycle pulse on each commit.
- bankSel  out  1  bank currently presented to the display.
- peakBin  out  ABITS  bin index of the max power in the last committed frame.
- peakMag  out  8  power at peakBin.
- cntSyncErr  out  8  saturating count of sequence errors.

Behaviour:
- Reset (async, while aresetn=0): state=stWaitSync, bankSel=0, flgFrameDone=0, peakBin=0, peakMag=0, cntSyncErr=0, byteDisplay=0, flgPrimed=0. RAM contents are undefined after reset.
- Storage: two banks of NBINS x 8 bits, with two read ports and one write port.
  - Capture bank = !bankSel; display bank = bankSel.
  - Read port A: the display (addrDisplay -> byteDisplay, registered, 1 cycle).
  - Read port B: the previous-average fetch from the display bank.
- Sample qualification: a sample is one with flgFreqSampleValid=1 and addrFreq<NBINS. Valid cycles with addrFreq>=NBINS are dropped silently and are not errors.
- FSM:
  - stWaitSync: on a sample with addrFreq=0, capture that sample, set expected=1, clear the peak trackers, go to stCapture. Other samples are dropped.
  - stCapture: on a sample with addrFreq==expected, capture it and increment expected.
    - If addrFreq==NBINS-1, go to stCommit.
    - On a sample with addrFreq!=expected: cntSyncErr+1 (saturates at 255).
    - If that sample has addrFreq=0, restart capture with it (expected=1, peak cleared) and stay in stCapture. Otherwise go to stWaitSync.
  - stCommit (exactly one cycle), then stWaitSync:
    - If flgFreeze=0: toggle bankSel, pulse flgFrameDone, load peakBin/peakMag from the trackers, set flgPrimed=1.
    - If flgFreeze=1: nothing changes and the capture bank is overwritten by the next frame.
    - Any sample arriving during stCommit is dropped.
- Capture pipeline:
  - Cycle t: accepted sample; port B reads old=displayBank[addrFreq]; register in and addr.
  - Cycle t+1: write new to captureBank[addr] and update the peak tracker.
  - new = in when flgPrimed=0 or k=0. Otherwise new = old + ((in - old) >>> k), using a 9-bit signed difference and arithmetic shift; the result always lies within 0..255, no clamp needed.
  - avgShift is sampled per sample.
- Peak tracker: considers bins 1..NBINS-1 only (DC bin 0 is excluded). Update on strictly greater, so ties keep the lowest bin. Tracked on the written (averaged) value.
- Commit timing: last sample (bin NBINS-1) valid at cycle t -> write at t+1 -> flgFrameDone=1 during t+2. bankSel, peakBin and peakMag change at the same edge.
  - A display read issued in the cycle before the toggle returns old-bank data.
  - Reads issued after the toggle return new-bank data. No mixed frame is ever visible.
- Back-to-back frames: the next addrFreq=0 may arrive at t+2 or later. If it arrives in stCommit it is dropped, and that frame is skipped (no error is counted).
- Reset mid-frame: the partial frame is discarded and the display bank is unspecified until the first commit.

Decomposition:
- Shared package: the FSM state encoding (stWaitSync, stCapture, stCommit) and the NBINS/ABITS defaults, reused by the display controller.
- One natural sub-module: spectrum_avg_ram, a bank-select dual-read/single-write 2 x NBINS x 8 memory with registered read outputs.
- The FSM, averaging datapath and peak tracker stay in the top.

Test Plan:
- Reset, then one frame: bins 0..511 with value = bin[7:0], k=0, freeze=0 -> flgFrameDone pulses 2 cycles after bin 511, bankSel=1. A display read at 37 returns 37 after 1 cycle. peakMag=255, peakBin=255 (lowest of tied bins 255 and 511).
- Averaging: frame A all 100, then frame B all 200 with k=1 -> display reads 150 everywhere after the second commit. With k=2 the second commit gives 125. Frame A followed by frame B all 0 with k=3 gives 100 + (-100>>>3) = 87.
- Sequence error: bins 0..99, then 150, then 0..511 -> cntSyncErr=1 and exactly one commit. The display matches the second frame only.
- Freeze: commit a frame, raise flgFreeze, send two different frames -> no flgFrameDone, bankSel unchanged, display data and peak unchanged. Drop freeze and send one frame -> it commits.
- Boundaries: bins 512..1023 interleaved with valid=1 -> no error. Bin 0 set to 255 -> excluded from peak. 256 consecutive errors followed by more errors -> cntSyncErr holds at 255.
- Async reset asserted mid-capture at bin 300 -> all outputs return to their reset values immediately. The next full frame commits with flgPrimed=0, so no averaging is applied.

Source files
------------

// File: rtl/spectrum_frame_buffer_pkg.sv
// spectrum_frame_buffer_pkg: capture FSM encoding and default frame geometry,
// shared by the frame buffer and the display controller.
package spectrum_frame_buffer_pkg;
    localparam int NBINS_DEF = 512;
    localparam int ABITS_DEF = 9;
    typedef enum logic [1:0] {stWaitSync, stCapture, stCommit} state_t;
endpackage

// File: rtl/spectrum_avg_ram.sv
// spectrum_avg_ram: 2 x NBINS x 8 ping-pong store, one write port and two
// registered read ports that both look at the bank chosen by rd_bank.
module spectrum_avg_ram import spectrum_frame_buffer_pkg::*; #(
    parameter int NBINS = NBINS_DEF,
    parameter int ABITS = ABITS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_bank,
    input  logic [ABITS-1:0] rd_a_addr,
    output logic [7:0]       rd_a_data,
    input  logic [ABITS-1:0] rd_b_addr,
    output logic [7:0]       rd_b_data,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [ABITS-1:0] wr_addr,
    input  logic [7:0]       wr_data
);
    logic [7:0] mem [2*NBINS];

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
        rd_b_data <= mem[{rd_bank, rd_b_addr}];
    end

    // The display port has a defined reset value; the fetch port does not need one.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rd_a_data <= '0;
        else rd_a_data <= mem[{rd_bank, rd_a_addr}];
endmodule

// File: rtl/spectrum_frame_buffer.sv
// spectrum_frame_buffer: captures FFT power frames into a ping-pong buffer with
// optional exponential averaging, peak tracking and a tear-free display read port.
module spectrum_frame_buffer import spectrum_frame_buffer_pkg::*; #(
    parameter int NBINS = NBINS_DEF,
    parameter int ABITS = ABITS_DEF
) (
    input  logic             ckFreq,
    input  logic             aresetn,
    input  logic             flgFreqSampleValid,
    input  logic [9:0]       addrFreq,
    input  logic [7:0]       byteFreqSample,
    input  logic             flgFreeze,
    input  logic [1:0]       avgShift,
    input  logic [ABITS-1:0] addrDisplay,
    output logic [7:0]       byteDisplay,
    output logic             flgFrameDone,
    output logic             bankSel,
    output logic [ABITS-1:0] peakBin,
    output logic [7:0]       peakMag,
    output logic [7:0]       cntSyncErr
);
    state_t state, state_nx;
    logic [ABITS-1:0] expected, smp_addr, p_addr, trk_bin, pk_bin_nx;
    logic [7:0] p_in, old_val, new_val, trk_mag, pk_mag_nx;
    logic [1:0] p_k;
    logic signed [8:0] diff, step;
    logic primed, p_vld, p_avg, smp, take, restart, seq_err, commit, trk_hit;

    assign smp      = flgFreqSampleValid && ({1'b0, addrFreq} < 11'(NBINS));
    assign smp_addr = addrFreq[ABITS-1:0];
    assign commit   = (state == stCommit) && !flgFreeze;

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        restart  = 1'b0;
        seq_err  = 1'b0;
        case (state)
            stWaitSync: begin
                take     = smp && (smp_addr == '0);
                restart  = take;
                state_nx = take ? stCapture : stWaitSync;
            end
            stCapture: begin
                if (smp && smp_addr == expected) begin
                    take     = 1'b1;
                    state_nx = (smp_addr == ABITS'(NBINS - 1)) ? stCommit : stCapture;
                end else if (smp) begin
                    seq_err  = 1'b1;
                    take     = (smp_addr == '0);
                    restart  = take;
                    state_nx = take ? stCapture : stWaitSync;
                end
            end
            default: state_nx = stWaitSync;
        endcase
    end

    always_ff @(posedge ckFreq or negedge aresetn)
        if (!aresetn) state <= stWaitSync;
        else state <= state_nx;

    // Averaging: 9-bit signed step toward the new sample; the sum stays in 0..255.
    assign diff    = $signed({1'b0, p_in}) - $signed({1'b0, old_val});
    assign step    = diff >>> p_k;
    assign new_val = p_avg ? old_val + step[7:0] : p_in;

    // The last bin is written in the commit cycle, so the committed peak folds it in.
    assign trk_hit   = p_vld && (p_addr != '0) && (new_val > trk_mag);
    assign pk_bin_nx = trk_hit ? p_addr : trk_bin;
    assign pk_mag_nx = trk_hit ? new_val : trk_mag;

    always_ff @(posedge ckFreq or negedge aresetn) begin
        if (!aresetn) begin
            expected     <= '0;
            primed       <= 1'b0;
            p_vld        <= 1'b0;
            p_addr       <= '0;
            p_in         <= '0;
            p_k          <= '0;
            p_avg        <= 1'b0;
            trk_bin      <= '0;
            trk_mag      <= '0;
            flgFrameDone <= 1'b0;
            bankSel      <= 1'b0;
            peakBin      <= '0;
            peakMag      <= '0;
            cntSyncErr   <= '0;
        end else begin
            p_vld        <= take;
            flgFrameDone <= commit;
            if (take) begin
                p_addr   <= smp_addr;
                p_in     <= byteFreqSample;
                p_k      <= avgShift;
                p_avg    <= primed && (avgShift != 2'd0);
                expected <= restart ? ABITS'(1) : expected + ABITS'(1);
            end
            if (seq_err && cntSyncErr != 8'hff) cntSyncErr <= cntSyncErr + 8'd1;
            if (restart) begin
                trk_bin <= '0;
                trk_mag <= '0;
            end else begin
                trk_bin <= pk_bin_nx;
                trk_mag <= pk_mag_nx;
            end
            if (commit) begin
                bankSel <= ~bankSel;
                peakBin <= pk_bin_nx;
                peakMag <= pk_mag_nx;
                primed  <= 1'b1;
            end
        end
    end

    spectrum_avg_ram #(.NBINS(NBINS), .ABITS(ABITS)) u_ram (
        .clk       (ckFreq),
        .rst_n     (aresetn),
        .rd_bank   (bankSel),
        .rd_a_addr (addrDisplay),
        .rd_a_data (byteDisplay),
        .rd_b_addr (smp_addr),
        .rd_b_data (old_val),
        .wr_en     (p_vld),
        .wr_bank   (~bankSel),
        .wr_addr   (p_addr),
        .wr_data   (new_val)
    );
endmodule

// File: tb/tb_spectrum_frame_buffer.sv
// tb_spectrum_frame_buffer: directed frames with hand-computed results; a monitor
// pops expected commits and display reads from queues as the DUT presents them.
module tb_spectrum_frame_buffer;
    localparam int NBINS = 512;
    localparam int ABITS = 9;

    logic             ckFreq = 1'b0;
    logic             aresetn = 1'b1;
    logic             flgFreqSampleValid = 1'b0;
    logic [9:0]       addrFreq = '0;
    logic [7:0]       byteFreqSample = '0;
    logic             flgFreeze = 1'b0;
    logic [1:0]       avgShift = '0;
    logic [ABITS-1:0] addrDisplay = '0;
    logic [7:0]       byteDisplay;
    logic             flgFrameDone;
    logic             bankSel;
    logic [ABITS-1:0] peakBin;
    logic [7:0]       peakMag;
    logic [7:0]       cntSyncErr;

    spectrum_frame_buffer #(.NBINS(NBINS), .ABITS(ABITS)) dut (
        .ckFreq             (ckFreq),
        .aresetn            (aresetn),
        .flgFreqSampleValid (flgFreqSampleValid),
        .addrFreq           (addrFreq),
        .byteFreqSample     (byteFreqSample),
        .flgFreeze          (flgFreeze),
        .avgShift           (avgShift),
        .addrDisplay        (addrDisplay),
        .byteDisplay        (byteDisplay),
        .flgFrameDone       (flgFrameDone),
        .bankSel            (bankSel),
        .peakBin            (peakBin),
        .peakMag            (peakMag),
        .cntSyncErr         (cntSyncErr)
    );

    always #5 ckFreq = ~ckFreq;

    typedef struct {
        logic [ABITS-1:0] bin;
        logic [7:0]       mag;
        logic             bank;
    } frame_t;

    int     n_chk = 0;
    int     n_fail = 0;
    frame_t fq[$];
    frame_t f;
    logic [7:0] dq[$];
    int     aq[$];
    logic   rd_req = 1'b0;
    logic   rd_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: display data one cycle after each read, commit records on each pulse.
    always @(posedge ckFreq) rd_pend <= rd_req;
    always @(negedge ckFreq) begin
        if (rd_pend && dq.size() > 0) chk($sformatf("rd[%0d]", aq.pop_front()), 32'(byteDisplay), 32'(dq.pop_front()));
        if (flgFrameDone) begin
            if (fq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_commit: peakBin=%0d peakMag=%0d bankSel=%0d", peakBin, peakMag, bankSel);
            end else begin
                f = fq.pop_front();
                chk("commit_peakBin", 32'(peakBin), 32'(f.bin));
                chk("commit_peakMag", 32'(peakMag), 32'(f.mag));
                chk("commit_bankSel", 32'(bankSel), 32'(f.bank));
            end
        end
    end

    task automatic tick();
        @(posedge ckFreq);
        #1;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic smp(input int a, input int v);
        flgFreqSampleValid = 1'b1;
        addrFreq = 10'(a);
        byteFreqSample = 8'(v);
        tick();
        flgFreqSampleValid = 1'b0;
    endtask

    task automatic rd(input int a, input int exp);
        addrDisplay = ABITS'(a);
        aq.push_back(a);
        dq.push_back(8'(exp));
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    task automatic expect_frame(input int bin, input int mag, input int bank);
        fq.push_back('{bin: ABITS'(bin), mag: 8'(mag), bank: 1'(bank)});
    endtask

    task automatic frame_const(input int v, input int k);
        avgShift = 2'(k);
        for (int i = 0; i < NBINS; i++) smp(i, v);
    endtask

    task automatic frame_ramp(input int x);
        avgShift = 2'd0;
        for (int i = 0; i < NBINS; i++) smp(i, (i & 255) ^ x);
    endtask

    task automatic do_reset();
        #2 aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_bankSel", 32'(bankSel), 0);
        chk("rst_frameDone", 32'(flgFrameDone), 0);
        chk("rst_peakBin", 32'(peakBin), 0);
        chk("rst_peakMag", 32'(peakMag), 0);
        chk("rst_syncErr", 32'(cntSyncErr), 0);
        chk("rst_display", 32'(byteDisplay), 0);

        // Ramp frame: pulse two cycles after bin 511, tie between 255 and 511 keeps 255.
        for (int i = 0; i < NBINS - 1; i++) smp(i, i & 255);
        expect_frame(255, 255, 1);
        smp(NBINS - 1, 255);
        chk("t1_done_early", 32'(flgFrameDone), 0);
        chk("t1_bank_early", 32'(bankSel), 0);
        tick();
        chk("t2_done", 32'(flgFrameDone), 1);
        chk("t2_bank", 32'(bankSel), 1);
        tick();
        chk("t3_done_off", 32'(flgFrameDone), 0);
        rd(37, 37);
        rd(511, 255);
        rd(300, 44);

        // Averaging with k = 1, 2, 3 after a primed frame of 100.
        do_reset();
        frame_const(100, 0); expect_frame(1, 100, 1); settle();
        frame_const(200, 1); expect_frame(1, 150, 0); settle();
        rd(0, 150); rd(1, 150); rd(511, 150);
        do_reset();
        frame_const(100, 0); expect_frame(1, 100, 1); settle();
        frame_const(200, 2); expect_frame(1, 125, 0); settle();
        rd(7, 125); rd(400, 125);
        do_reset();
        frame_const(100, 0); expect_frame(1, 100, 1); settle();
        frame_const(0, 3); expect_frame(1, 87, 0); settle();
        rd(3, 87); rd(511, 87);

        // Sequence error: partial frame broken by bin 150, then a clean frame.
        do_reset();
        avgShift = 2'd0;
        for (int i = 0; i < 100; i++) smp(i, 8'h33);
        smp(150, 8'h33);
        chk("seq_err_one", 32'(cntSyncErr), 1);
        expect_frame(165, 255, 1);
        frame_ramp(8'h5a);
        settle();
        chk("seq_err_after", 32'(cntSyncErr), 1);
        rd(50, 104); rd(99, 57); rd(150, 204);

        // Freeze: two frames are captured but never committed.
        flgFreeze = 1'b1;
        frame_const(7, 0); settle();
        frame_const(9, 0); settle();
        chk("frz_bank", 32'(bankSel), 1);
        chk("frz_peakBin", 32'(peakBin), 165);
        chk("frz_peakMag", 32'(peakMag), 255);
        rd(50, 104);
        flgFreeze = 1'b0;
        expect_frame(255, 255, 0);
        frame_ramp(0);
        settle();
        rd(37, 37);

        // Out-of-range bins interleaved, DC bin holds the largest value.
        avgShift = 2'd0;
        expect_frame(127, 127, 1);
        for (int i = 0; i < NBINS; i++) begin
            smp(i, (i == 0) ? 255 : (i & 127));
            smp(NBINS + i, 8'hee);
        end
        settle();
        chk("oor_no_err", 32'(cntSyncErr), 1);
        rd(0, 255); rd(127, 127); rd(200, 72);

        // Error counter saturation: repeated bin 0 restarts count one error each.
        do_reset();
        for (int i = 0; i < 100; i++) smp(0, 1);
        chk("sat_99", 32'(cntSyncErr), 99);
        for (int i = 0; i < 156; i++) smp(0, 1);
        chk("sat_255", 32'(cntSyncErr), 255);
        for (int i = 0; i < 10; i++) smp(0, 1);
        chk("sat_hold", 32'(cntSyncErr), 255);

        // Async reset mid-capture, then the next frame must not be averaged.
        expect_frame(1, 100, 1);
        frame_const(100, 0);
        settle();
        rd(5, 100);
        for (int i = 0; i <= 300; i++) smp(i, 40);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_bank", 32'(bankSel), 0);
        chk("arst_done", 32'(flgFrameDone), 0);
        chk("arst_peakBin", 32'(peakBin), 0);
        chk("arst_peakMag", 32'(peakMag), 0);
        chk("arst_syncErr", 32'(cntSyncErr), 0);
        chk("arst_display", 32'(byteDisplay), 0);
        tick();
        aresetn = 1'b1;
        tick();
        expect_frame(1, 200, 1);
        frame_const(200, 1);
        settle();
        rd(5, 200); rd(511, 200);

        settle();
        chk("commits_missing", 32'(fq.size()), 0);
        chk("reads_missing", 32'(dq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
